// File: rtl/sd_init_sequencer.sv
// Drives the SPI-mode SD byte engine through CMD0, CMD8 and the CMD55+ACMD41 loop after reset.
// Reports ready or a coded error; responses arrive as toggle-per-byte strobes from the engine.
module sd_init_sequencer #(
  parameter int POWERUP_CYCLES   = 80,
  parameter int NCR_MAX          = 16,
  parameter int ACMD41_RETRY_MAX = 255,
  parameter int GAP_CYCLES       = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init_go,
  output logic [47:0] cmd,
  output logic        cmd_start,
  output logic        cmd_abort,
  input  logic        resp_toggle,
  input  logic [7:0]  resp_byte,
  output logic        busy,
  output logic        ready,
  output logic        error,
  output logic [2:0]  err_code
);

  localparam int CYC_MAX = (POWERUP_CYCLES > GAP_CYCLES) ? POWERUP_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(CYC_MAX + 1);
  localparam int BW = $clog2(NCR_MAX + 1);
  localparam int RW = $clog2(ACMD41_RETRY_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, POWERUP, SEND, WAIT_R1, R7_TAIL, GAP, DONE, ERROR
  } state_t;

  typedef enum logic [1:0] {
    C_CMD0, C_CMD8, C_CMD55, C_ACMD41
  } cmdSel_t;

  function automatic logic [47:0] frameOf(input cmdSel_t s);
    case (s)
      C_CMD0:  frameOf = 48'h40_00000000_95;
      C_CMD8:  frameOf = 48'h48_000001AA_87;
      C_CMD55: frameOf = 48'h77_00000000_65;
      default: frameOf = 48'h69_40000000_77;
    endcase
  endfunction

  state_t         state, stateN;
  cmdSel_t        cmdSel, cmdSelN;
  logic [47:0]    cmdReg, cmdRegN;
  logic [CW-1:0]  cycCnt, cycCntN;
  logic [BW-1:0]  byteCnt, byteCntN, byteInc;
  logic [RW-1:0]  retryCnt, retryCntN, retryInc;
  logic [1:0]     tailCnt, tailCntN;
  logic           tailOk, tailOkN;
  logic [2:0]     errCode, errCodeN;
  logic           togQ;
  logic           byteEv;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cmdSel   <= C_CMD0;
      cmdReg   <= 48'h0;
      cycCnt   <= '0;
      byteCnt  <= '0;
      retryCnt <= '0;
      tailCnt  <= '0;
      tailOk   <= 1'b0;
      errCode  <= 3'd0;
      togQ     <= 1'b0;
    end else begin
      state    <= stateN;
      cmdSel   <= cmdSelN;
      cmdReg   <= cmdRegN;
      cycCnt   <= cycCntN;
      byteCnt  <= byteCntN;
      retryCnt <= retryCntN;
      tailCnt  <= tailCntN;
      tailOk   <= tailOkN;
      errCode  <= errCodeN;
      // Tracks the strobe every cycle, so flips outside a response window are dropped.
      togQ     <= resp_toggle;
    end
  end

  always_comb begin
    stateN    = state;
    cmdSelN   = cmdSel;
    cmdRegN   = cmdReg;
    cycCntN   = cycCnt;
    byteCntN  = byteCnt;
    retryCntN = retryCnt;
    tailCntN  = tailCnt;
    tailOkN   = tailOk;
    errCodeN  = errCode;
    byteEv    = resp_toggle ^ togQ;
    byteInc   = (byteCnt == BW'(NCR_MAX)) ? byteCnt : byteCnt + 1'b1;
    retryInc  = retryCnt + 1'b1;

    cmd       = cmdReg;
    cmd_start = (state == SEND);
    cmd_abort = !((state == SEND) || (state == WAIT_R1) || (state == R7_TAIL));
    busy      = !((state == IDLE) || (state == DONE) || (state == ERROR));
    ready     = (state == DONE);
    error     = (state == ERROR);
    err_code  = errCode;

    case (state)
      IDLE: begin
        if (init_go) begin
          stateN  = POWERUP;
          cycCntN = '0;
        end
      end
      POWERUP: begin
        if (cycCnt == CW'(POWERUP_CYCLES - 1)) begin
          stateN  = SEND;
          cmdSelN = C_CMD0;
          cmdRegN = frameOf(C_CMD0);
        end else begin
          cycCntN = cycCnt + 1'b1;
        end
      end
      SEND: begin
        byteCntN = '0;
        tailCntN = '0;
        stateN   = WAIT_R1;
      end
      WAIT_R1: begin
        if (byteEv) begin
          byteCntN = byteInc;
          cycCntN  = '0;
          // A valid R1 on the last permitted byte takes priority over the timeout.
          if (!resp_byte[7]) begin
            case (cmdSel)
              C_CMD0: begin
                if (resp_byte == 8'h01) begin
                  stateN  = GAP;
                  cmdSelN = C_CMD8;
                end else begin
                  stateN   = ERROR;
                  errCodeN = 3'd1;
                end
              end
              C_CMD8: begin
                if (resp_byte == 8'h01) begin
                  stateN = R7_TAIL;
                end else begin
                  stateN   = ERROR;
                  errCodeN = 3'd2;
                end
              end
              C_CMD55: begin
                if (resp_byte == 8'h01 || resp_byte == 8'h00) begin
                  stateN  = GAP;
                  cmdSelN = C_ACMD41;
                end else begin
                  stateN   = ERROR;
                  errCodeN = 3'd5;
                end
              end
              default: begin
                if (resp_byte == 8'h00) begin
                  stateN = DONE;
                end else if (resp_byte == 8'h01 && retryInc != RW'(ACMD41_RETRY_MAX)) begin
                  retryCntN = retryInc;
                  stateN    = GAP;
                  cmdSelN   = C_CMD55;
                end else begin
                  retryCntN = (resp_byte == 8'h01) ? retryInc : retryCnt;
                  stateN    = ERROR;
                  errCodeN  = 3'd3;
                end
              end
            endcase
          end else if (byteInc == BW'(NCR_MAX)) begin
            stateN   = ERROR;
            errCodeN = 3'd4;
          end
        end
      end
      R7_TAIL: begin
        if (byteEv) begin
          tailCntN = tailCnt + 1'b1;
          cycCntN  = '0;
          if (tailCnt == 2'd2) begin
            tailOkN = (resp_byte[3:0] == 4'h1);
          end
          if (tailCnt == 2'd3) begin
            if (tailOk && resp_byte == 8'hAA) begin
              stateN  = GAP;
              cmdSelN = C_CMD55;
            end else begin
              stateN   = ERROR;
              errCodeN = 3'd2;
            end
          end
        end
      end
      GAP: begin
        if (cycCnt == CW'(GAP_CYCLES - 1)) begin
          stateN  = SEND;
          cmdRegN = frameOf(cmdSel);
        end else begin
          cycCntN = cycCnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Directed bench for sd_init_sequencer: a scripted card model answers each frame,
// and each test task checks the sequence, timing boundaries and coded errors.
module tb_sd_init_sequencer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        init_go;
  logic [47:0] cmd;
  logic        cmd_start;
  logic        cmd_abort;
  logic        resp_toggle;
  logic [7:0]  resp_byte;
  logic        busy;
  logic        ready;
  logic        error;
  logic [2:0]  err_code;

  int checks = 0;
  int passed = 0;
  int scen = 0;
  int acmdSeen = 0;
  logic [47:0] frames[$];

  localparam logic [47:0] F0  = 48'h40_00000000_95;
  localparam logic [47:0] F8  = 48'h48_000001AA_87;
  localparam logic [47:0] F55 = 48'h77_00000000_65;
  localparam logic [47:0] F41 = 48'h69_40000000_77;
  localparam int SC_NORMAL = 0, SC_TIMEOUT = 1, SC_BADTAIL = 2, SC_ALWAYS1 = 3, SC_LATE = 4, SC_HANG = 5;

  always #5 clk = ~clk;

  sd_init_sequencer #(.ACMD41_RETRY_MAX(3)) dut (
    .clk(clk), .reset_n(reset_n), .init_go(init_go), .cmd(cmd), .cmd_start(cmd_start),
    .cmd_abort(cmd_abort), .resp_toggle(resp_toggle), .resp_byte(resp_byte), .busy(busy),
    .ready(ready), .error(error), .err_code(err_code)
  );

  task automatic send_byte(input logic [7:0] b);
    repeat (2) @(posedge clk);
    #1;
    resp_byte   = b;
    resp_toggle = ~resp_toggle;
  endtask

  // Card model: records every started frame and answers according to the scenario.
  initial begin : card_model
    resp_toggle = 1'b0;
    resp_byte   = 8'hFF;
    forever begin
      @(posedge clk);
      #1;
      if (cmd_start) begin
        frames.push_back(cmd);
        case (cmd[47:40])
          8'h40: begin
            acmdSeen = 0;
            if (scen == SC_TIMEOUT) repeat (16) send_byte(8'hFF);
            else if (scen == SC_LATE) begin
              repeat (15) send_byte(8'hFF);
              send_byte(8'h01);
            end else begin
              send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h01);
            end
          end
          8'h48: begin
            send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
            send_byte(scen == SC_BADTAIL ? 8'h55 : 8'hAA);
          end
          8'h77: send_byte(8'h01);
          8'h69: begin
            if (scen != SC_HANG) send_byte((scen == SC_ALWAYS1 || acmdSeen < 2) ? 8'h01 : 8'h00);
            acmdSeen++;
          end
          default: ;
        endcase
      end
    end
  end

  task automatic do_reset();
    init_go = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Raises init_go and counts busy cycles before the first cmd_start, then drops init_go.
  task automatic start_seq(input int sc, output int puCycles);
    scen = sc;
    puCycles = 0;
    @(negedge clk);
    init_go = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (cmd_start) break;
      if (busy) puCycles++;
    end
    @(negedge clk);
    init_go = 1'b0;
  endtask

  task automatic wait_end(input string nm);
    for (int i = 0; i < 4000 && !(ready || error); i++) @(posedge clk);
    checks++;
    if (!(ready || error)) $display("FAIL %s_end: ready=%0b error=%0b, sequence never finished", nm, ready, error);
    else passed++;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    init_go = 1'b0;
    #2;
    checks++; if (cmd !== 48'h0) $display("FAIL rst_cmd: got %h want 0", cmd); else passed++;
    checks++; if (cmd_start !== 1'b0) $display("FAIL rst_start: got %b want 0", cmd_start); else passed++;
    checks++; if (cmd_abort !== 1'b1) $display("FAIL rst_abort: got %b want 1", cmd_abort); else passed++;
    checks++; if ({busy, ready, error} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {busy, ready, error}); else passed++;
    checks++; if (err_code !== 3'd0) $display("FAIL rst_code: got %0d want 0", err_code); else passed++;
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else passed++;
  endtask

  task automatic test_success();
    int pu, base;
    logic [47:0] exp [8];
    exp = '{F0, F8, F55, F41, F55, F41, F55, F41};
    do_reset();
    base = frames.size();
    start_seq(SC_NORMAL, pu);
    checks++; if (pu != 80) $display("FAIL powerup_cycles: got %0d want 80", pu); else passed++;
    wait_end("success");
    checks++; if (frames.size() - base != 8) $display("FAIL success_count: got %0d want 8", frames.size() - base); else passed++;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (frames[base + k] !== exp[k]) $display("FAIL success_frame%0d: got %h want %h", k, frames[base + k], exp[k]);
      else passed++;
    end
    checks++; if ({ready, error, busy, cmd_abort} !== 4'b1001) $display("FAIL success_flags: got %b want 1001", {ready, error, busy, cmd_abort}); else passed++;
    @(negedge clk);
    init_go = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    init_go = 1'b0;
    checks++; if (frames.size() - base != 8 || ready !== 1'b1) $display("FAIL done_sticky: frames=%0d ready=%b want 8/1", frames.size() - base, ready); else passed++;
  endtask

  task automatic test_timeout();
    int pu, base;
    do_reset();
    base = frames.size();
    start_seq(SC_TIMEOUT, pu);
    wait_end("timeout");
    repeat (40) @(posedge clk);
    #1;
    checks++; if (error !== 1'b1 || err_code !== 3'd4) $display("FAIL timeout_code: error=%b code=%0d want 1/4", error, err_code); else passed++;
    checks++; if (frames.size() - base != 1) $display("FAIL timeout_frames: got %0d want 1", frames.size() - base); else passed++;
    checks++; if ({ready, busy} !== 2'b00) $display("FAIL timeout_flags: ready,busy=%b want 00", {ready, busy}); else passed++;
  endtask

  task automatic test_bad_tail();
    int pu, base;
    do_reset();
    base = frames.size();
    start_seq(SC_BADTAIL, pu);
    wait_end("badtail");
    checks++; if (error !== 1'b1 || err_code !== 3'd2) $display("FAIL badtail_code: error=%b code=%0d want 1/2", error, err_code); else passed++;
    checks++; if (cmd_abort !== 1'b1) $display("FAIL badtail_abort: got %b want 1", cmd_abort); else passed++;
    checks++; if (frames.size() - base != 2) $display("FAIL badtail_frames: got %0d want 2", frames.size() - base); else passed++;
  endtask

  task automatic test_retry_limit();
    int pu, base, nAcmd;
    do_reset();
    base = frames.size();
    start_seq(SC_ALWAYS1, pu);
    wait_end("retry");
    nAcmd = 0;
    for (int k = base; k < frames.size(); k++) if (frames[k] === F41) nAcmd++;
    checks++; if (nAcmd != 3) $display("FAIL retry_acmd41: got %0d want 3", nAcmd); else passed++;
    checks++; if (error !== 1'b1 || err_code !== 3'd3) $display("FAIL retry_code: error=%b code=%0d want 1/3", error, err_code); else passed++;
    checks++; if (frames.size() - base != 8) $display("FAIL retry_frames: got %0d want 8", frames.size() - base); else passed++;
  endtask

  task automatic test_late_r1();
    int pu, base;
    do_reset();
    base = frames.size();
    start_seq(SC_LATE, pu);
    wait_end("late");
    checks++; if (frames.size() - base < 2 || frames[base + 1] !== F8) $display("FAIL late_cmd8: frames=%0d want CMD8 second", frames.size() - base); else passed++;
    checks++; if (ready !== 1'b1 || error !== 1'b0) $display("FAIL late_ready: ready=%b error=%b want 1/0", ready, error); else passed++;
  endtask

  task automatic test_reset_mid();
    int pu, base;
    do_reset();
    base = frames.size();
    start_seq(SC_HANG, pu);
    for (int i = 0; i < 2000 && frames.size() - base < 4; i++) @(posedge clk);
    checks++; if (frames.size() - base != 4) $display("FAIL mid_reach_acmd41: frames=%0d want 4", frames.size() - base); else passed++;
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (cmd_abort !== 1'b1 || cmd_start !== 1'b0) $display("FAIL mid_abort: abort=%b start=%b want 1/0", cmd_abort, cmd_start); else passed++;
    checks++; if (cmd !== 48'h0 || {busy, ready, error} !== 3'b000 || err_code !== 3'd0) $display("FAIL mid_outputs: cmd=%h flags=%b code=%0d want 0", cmd, {busy, ready, error}, err_code); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    base = frames.size();
    start_seq(SC_NORMAL, pu);
    checks++; if (pu != 80) $display("FAIL mid_powerup: got %0d want 80", pu); else passed++;
    checks++; if (frames.size() - base < 1 || frames[base] !== F0) $display("FAIL mid_first_cmd0: frames=%0d want CMD0 first", frames.size() - base); else passed++;
    wait_end("mid_restart");
    checks++; if (ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", ready); else passed++;
  endtask

  initial begin
    test_reset();
    test_success();
    test_timeout();
    test_bad_tail();
    test_retry_limit();
    test_late_r1();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
